// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller.
//   state_e : controller states (off, running, running with a config pending)
//   MIN_DIV : smallest divisor the divider will ever run at
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        StOff,
        StRun,
        StSwitch
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, divisor register and clk_out/tick generation.
// Ports:
//   clk_in, rst_n : clock, synchronous active-low reset
//   run           : the divider is counting in the next cycle
//   load          : load load_div as the new divisor and restart the period at 0
//   load_div      : divisor to load (already clamped by the controller)
//   last          : counter is at N-1 (period boundary)
//   clk_out, tick : registered divided clock and period-start pulse
module clk_div_core #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             last,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             clk_out_d, tick_d;

    assign last = (cnt_q == n_q - WIDTH'(1));

    // Outputs are computed from the next counter value so the registered
    // clk_out/tick line up with the cycle in which cnt holds that value.
    always_comb begin
        n_d = load ? load_div : n_q;
        if (!run || load || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        clk_out_d = run && (cnt_d < (n_d >> 1));
        tick_d    = run && (cnt_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            n_q     <= WIDTH'(DEFAULT_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            clk_out <= clk_out_d;
            tick    <= tick_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with a valid/ready configuration port.
// New settings take effect only at a period boundary, so clk_out never shows a
// runt pulse; a request arriving mid-period is parked until the boundary.
// Ports:
//   clk_in, rst_n         : clock, synchronous active-low reset
//   cfg_valid / cfg_ready : configuration handshake
//   cfg_div, cfg_enable   : requested divisor (0/1 clamp to 2) and run/stop
//   clk_out, tick         : divided clock and pulse on each clk_out rising edge
//   busy                  : divider is running (or finishing a period before a switch)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_enable,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_div_q;
    logic             pend_en_q;
    logic             accept;
    logic [WIDTH-1:0] cfg_div_eff;
    logic             load;
    logic [WIDTH-1:0] load_div;
    logic             run;
    logic             last;

    always_comb begin
        accept      = cfg_valid && cfg_ready;
        cfg_div_eff = (cfg_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : cfg_div;
        state_d     = state_q;
        load        = 1'b0;
        load_div    = cfg_div_eff;
        unique case (state_q)
            StOff: begin
                if (accept) begin
                    load = 1'b1;
                    if (cfg_enable) state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    if (last) begin
                        // Request lands exactly on the boundary: apply it directly.
                        load    = 1'b1;
                        state_d = cfg_enable ? StRun : StOff;
                    end else begin
                        state_d = StSwitch;
                    end
                end
            end
            StSwitch: begin
                if (last) begin
                    load     = 1'b1;
                    load_div = pend_div_q;
                    state_d  = pend_en_q ? StRun : StOff;
                end
            end
            default: state_d = StOff;
        endcase
        run = (state_d != StOff);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= StOff;
            pend_div_q <= '0;
            pend_en_q  <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == StRun && accept && !last) begin
                pend_div_q <= cfg_div_eff;
                pend_en_q  <= cfg_enable;
            end
            busy      <= (state_d != StOff);
            cfg_ready <= (state_d != StSwitch);
        end
    end

    clk_div_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (run),
        .load     (load),
        .load_div (load_div),
        .last     (last),
        .clk_out  (clk_out),
        .tick     (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: a cycle-level behavioural model of the
// divider (on/off, phase within period, divisor, parked request) is compared with
// the DUT after every clock, plus literal expectations for the directed scenarios.
module tb_clk_div_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_div = '0;
    logic        cfg_enable = 1'b0;
    logic        clk_out;
    logic        tick;
    logic        busy;

    int checks = 0;
    int passed = 0;

    // Behavioural model state
    bit m_on;
    int m_cnt;
    int m_n;
    bit m_pv;
    int m_pn;
    bit m_pe;

    logic [15:0] seq_clk;
    logic [15:0] seq_tick;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .WIDTH       (16),
        .DEFAULT_DIV (5)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_enable (cfg_enable),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int d, input bit e);
        int cd;
        bit acc;
        cd = (d < 2) ? 2 : d;
        if (!r) begin
            m_on = 0; m_cnt = 0; m_n = 5; m_pv = 0;
        end else begin
            acc = v && !m_pv;
            if (!m_on) begin
                if (acc) begin
                    m_n = cd;
                    if (e) begin m_on = 1; m_cnt = 0; end
                end
            end else if (m_cnt == m_n - 1) begin
                if (m_pv) begin
                    m_n = m_pn; m_cnt = 0; m_on = m_pe; m_pv = 0;
                end else if (acc) begin
                    m_n = cd; m_cnt = 0; m_on = e;
                end else begin
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (acc) begin m_pv = 1; m_pn = cd; m_pe = e; end
            end
        end
    endtask

    // Drive inputs, clock once, advance the model, then compare at the falling edge.
    task automatic step(input bit r, input bit v, input int d, input bit e);
        rst_n      = r;
        cfg_valid  = v;
        cfg_div    = d[15:0];
        cfg_enable = e;
        @(posedge clk_in);
        model_edge(r, v, d, e);
        @(negedge clk_in);
        chk("model clk_out", {15'd0, clk_out}, {15'd0, m_on && (m_cnt < m_n / 2)});
        chk("model tick", {15'd0, tick}, {15'd0, m_on && (m_cnt == 0)});
        chk("model busy", {15'd0, busy}, {15'd0, m_on});
        chk("model cfg_ready", {15'd0, cfg_ready}, {15'd0, !m_pv});
        seq_clk  = {seq_clk[14:0], clk_out};
        seq_tick = {seq_tick[14:0], tick};
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset clk_out", {15'd0, clk_out}, 16'd0);
        chk("reset tick", {15'd0, tick}, 16'd0);
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset cfg_ready", {15'd0, cfg_ready}, 16'd1);

        // Enable at N=5: 2 high / 3 low, tick every 5 cycles
        seq_clk = '0; seq_tick = '0;
        step(1, 1, 5, 1);
        chk("first run busy", {15'd0, busy}, 16'd1);
        idle(9);
        chk("n5 clk_out pattern", seq_clk & 16'h03ff, 16'b1100011000);
        chk("n5 tick pattern", seq_tick & 16'h03ff, 16'b1000010000);

        // Accepted exactly at cnt==N-1: switches to N=3 with no parked cycle
        seq_clk = '0; seq_tick = '0;
        step(1, 1, 3, 1);
        chk("boundary cfg_ready", {15'd0, cfg_ready}, 16'd1);
        idle(3);
        chk("n3 clk_out pattern", seq_clk & 16'h000f, 16'b1001);
        chk("n3 tick pattern", seq_tick & 16'h000f, 16'b1001);

        // Mid-period request to N=8 is parked until the N=5 period completes
        step(0, 0, 0, 0);
        step(1, 1, 5, 1);
        idle(1);
        step(1, 1, 8, 1);
        chk("switch cfg_ready low", {15'd0, cfg_ready}, 16'd0);
        idle(2);
        chk("switch still low", {15'd0, cfg_ready}, 16'd0);
        seq_clk = '0;
        idle(8);
        chk("n8 clk_out pattern", seq_clk & 16'h00ff, 16'b11110000);
        chk("n8 cfg_ready", {15'd0, cfg_ready}, 16'd1);

        // Stop requested at cnt=0: period finishes, then off
        step(0, 0, 0, 0);
        step(1, 1, 5, 1);
        step(1, 1, 5, 0);
        idle(3);
        chk("stop still busy", {15'd0, busy}, 16'd1);
        idle(1);
        chk("stop busy", {15'd0, busy}, 16'd0);
        chk("stop clk_out", {15'd0, clk_out}, 16'd0);
        chk("stop tick", {15'd0, tick}, 16'd0);

        // Divisors 0 and 1 clamp to 2
        seq_clk = '0; seq_tick = '0;
        step(1, 1, 0, 1);
        idle(3);
        chk("div0 clk_out pattern", seq_clk & 16'h000f, 16'b1010);
        chk("div0 tick pattern", seq_tick & 16'h000f, 16'b1010);
        seq_clk = '0;
        step(1, 1, 1, 1);
        idle(3);
        chk("div1 clk_out pattern", seq_clk & 16'h000f, 16'b1010);

        // Reset mid-period aborts immediately; re-enable restarts cleanly
        step(0, 0, 0, 0);
        step(1, 1, 5, 1);
        idle(3);
        step(0, 0, 0, 0);
        chk("midreset clk_out", {15'd0, clk_out}, 16'd0);
        chk("midreset busy", {15'd0, busy}, 16'd0);
        chk("midreset cfg_ready", {15'd0, cfg_ready}, 16'd1);
        step(1, 1, 5, 1);
        chk("restart clk_out", {15'd0, clk_out}, 16'd1);
        chk("restart tick", {15'd0, tick}, 16'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20))
                                            : int'($urandom_range(0, 9));
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, d,
                 $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
